// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-SRAM port arbiter: data/address width
// and the arbiter state encoding.
package mem_port_arbiter_pkg;

   localparam int WORD_LEN = 32;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_DATA  = 2'd1,
      ARB_FETCH = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and the memory
// stage. Data accesses win over fetches. The SRAM handshake values are latched
// at grant time and held until the SRAM reports ready. Read data comes back
// with one-cycle valid pulses. A branch flush discards an in-flight fetch.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [WORD_LEN-1:0] if_addr,
   input  logic                flush,
   output logic [WORD_LEN-1:0] if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                mem_rd,
   input  logic                mem_wr,
   input  logic [WORD_LEN-1:0] mem_addr,
   input  logic [WORD_LEN-1:0] mem_wdata,
   output logic [WORD_LEN-1:0] mem_rdata,
   output logic                mem_valid,
   output logic                mem_stall,
   output logic                sram_req,
   output logic                sram_we,
   output logic [WORD_LEN-1:0] sram_addr,
   output logic [WORD_LEN-1:0] sram_wdata,
   input  logic [WORD_LEN-1:0] sram_rdata,
   input  logic                sram_ready
);

   arb_state_t state;
   logic       flush_pend;
   logic       data_pend;
   logic       fetch_pend;

   // During a requester's valid-pulse cycle its request still looks high,
   // because the pipeline has not advanced yet. That pulse masks the
   // request so the arbiter does not grant it a second time.
   assign data_pend  = (mem_rd | mem_wr) & ~mem_valid;
   assign fetch_pend = if_req & ~if_valid;
   assign mem_stall  = data_pend;
   assign if_stall   = data_pend | fetch_pend;

   // Arbitration FSM. It also owns every registered output: the SRAM
   // handshake latches, the returned data and the valid pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         flush_pend <= 1'b0;
         sram_req   <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         if_rdata   <= '0;
         if_valid   <= 1'b0;
         mem_rdata  <= '0;
         mem_valid  <= 1'b0;
      end else begin
         if_valid  <= 1'b0;
         mem_valid <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (data_pend) begin
                  state      <= ARB_DATA;
                  sram_req   <= 1'b1;
                  sram_we    <= mem_wr;
                  sram_addr  <= mem_addr;
                  sram_wdata <= mem_wdata;
               end else if (fetch_pend) begin
                  state      <= ARB_FETCH;
                  sram_req   <= 1'b1;
                  sram_we    <= 1'b0;
                  sram_addr  <= if_addr;
                  flush_pend <= 1'b0;
               end
            end
            ARB_DATA: begin
               if (sram_ready) begin
                  if (!sram_we) begin
                     mem_rdata <= sram_rdata;
                  end
                  mem_valid <= 1'b1;
                  sram_req  <= 1'b0;
                  state     <= ARB_IDLE;
               end
            end
            ARB_FETCH: begin
               if (sram_ready) begin
                  if_rdata   <= sram_rdata;
                  if_valid   <= ~(flush_pend | flush);
                  sram_req   <= 1'b0;
                  flush_pend <= 1'b0;
                  state      <= ARB_IDLE;
               end else if (flush) begin
                  flush_pend <= 1'b1;
               end
            end
            default: begin
               state    <= ARB_IDLE;
               sram_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. An access-level reference model runs next to
// the design. Directed scenarios exercise fetch, conflict, store, flush,
// reset and zero-wait SRAM, and then a long random run follows.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                if_req;
   logic [WORD_LEN-1:0] if_addr;
   logic                flush;
   logic [WORD_LEN-1:0] if_rdata;
   logic                if_valid;
   logic                if_stall;
   logic                mem_rd;
   logic                mem_wr;
   logic [WORD_LEN-1:0] mem_addr;
   logic [WORD_LEN-1:0] mem_wdata;
   logic [WORD_LEN-1:0] mem_rdata;
   logic                mem_valid;
   logic                mem_stall;
   logic                sram_req;
   logic                sram_we;
   logic [WORD_LEN-1:0] sram_addr;
   logic [WORD_LEN-1:0] sram_wdata;
   logic [WORD_LEN-1:0] sram_rdata;
   logic                sram_ready;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .flush      (flush),
      .if_rdata   (if_rdata),
      .if_valid   (if_valid),
      .if_stall   (if_stall),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_valid  (mem_valid),
      .mem_stall  (mem_stall),
      .sram_req   (sram_req),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready)
   );

   int checks = 0;
   int errors = 0;

   // One outstanding SRAM access, viewed as a transaction record.
   typedef struct packed {
      logic        active;
      logic        is_data;
      logic        we;
      logic        killed;
      logic [31:0] addr;
      logic [31:0] wdata;
   } access_t;

   access_t     cur;
   logic [31:0] exp_mem_rdata;
   logic [31:0] exp_if_rdata;
   logic        exp_mem_valid;
   logic        exp_if_valid;
   int          cyc = 0;
   int          last_if_cyc = -10;
   int          last_mem_cyc = -10;
   int          n_if = 0;
   int          n_mem = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance the reference by one clock, using the inputs seen at the edge.
   task automatic modelEdge();
      logic nm;
      logic ni;
      nm = 1'b0;
      ni = 1'b0;
      if (rst) begin
         cur           = '0;
         exp_mem_rdata = '0;
         exp_if_rdata  = '0;
      end else if (!cur.active) begin
         if ((mem_rd || mem_wr) && !exp_mem_valid) begin
            cur.active  = 1'b1;
            cur.is_data = 1'b1;
            cur.we      = mem_wr;
            cur.killed  = 1'b0;
            cur.addr    = mem_addr;
            cur.wdata   = mem_wdata;
         end else if (if_req && !exp_if_valid) begin
            cur.active  = 1'b1;
            cur.is_data = 1'b0;
            cur.we      = 1'b0;
            cur.killed  = 1'b0;
            cur.addr    = if_addr;
         end
      end else begin
         if (!cur.is_data && flush) cur.killed = 1'b1;
         if (sram_ready) begin
            if (cur.is_data) begin
               nm = 1'b1;
               if (!cur.we) exp_mem_rdata = sram_rdata;
            end else begin
               exp_if_rdata = sram_rdata;
               ni = !cur.killed;
            end
            cur.active = 1'b0;
         end
      end
      exp_mem_valid = nm;
      exp_if_valid  = ni;
   endtask

   // One clock cycle: check the stall outputs against the current inputs,
   // cross the edge, then check the registered outputs 1ns after it.
   task automatic stepCycle();
      logic dp;
      #1;
      dp = (mem_rd | mem_wr) & ~exp_mem_valid;
      checkOutput("mem_stall", 32'(mem_stall), 32'(dp));
      checkOutput("if_stall", 32'(if_stall), 32'(dp | (if_req & ~exp_if_valid)));
      @(posedge clk);
      modelEdge();
      cyc++;
      #1;
      checkOutput("sram_req", 32'(sram_req), 32'(cur.active));
      if (cur.active) begin
         checkOutput("sram_addr", sram_addr, cur.addr);
         checkOutput("sram_we", 32'(sram_we), 32'(cur.we));
         if (cur.we) checkOutput("sram_wdata", sram_wdata, cur.wdata);
      end
      checkOutput("mem_valid", 32'(mem_valid), 32'(exp_mem_valid));
      checkOutput("if_valid", 32'(if_valid), 32'(exp_if_valid));
      checkOutput("mem_rdata", mem_rdata, exp_mem_rdata);
      checkOutput("if_rdata", if_rdata, exp_if_rdata);
      if (if_valid) begin
         checkOutput("if_spacing", 32'((cyc - last_if_cyc) >= 3), 32'd1);
         last_if_cyc = cyc;
         n_if++;
      end
      if (mem_valid) begin
         checkOutput("mem_spacing", 32'((cyc - last_mem_cyc) >= 3), 32'd1);
         last_mem_cyc = cyc;
         n_mem++;
      end
   endtask

   task automatic applyStimulus();
      int op;
      rst        = ($urandom_range(0, 99) == 0);
      if_req     = ($urandom_range(0, 2) != 0);
      if_addr    = $urandom & 32'hFFFF_FFFC;
      op         = $urandom_range(0, 5);
      mem_rd     = (op < 2);
      mem_wr     = (op == 2);
      mem_addr   = $urandom;
      mem_wdata  = $urandom;
      flush      = ($urandom_range(0, 7) == 0);
      sram_ready = ($urandom_range(0, 2) == 0);
      sram_rdata = $urandom;
   endtask

   initial begin
      logic [31:0] saved;
      cur           = '0;
      exp_mem_rdata = '0;
      exp_if_rdata  = '0;
      exp_mem_valid = 1'b0;
      exp_if_valid  = 1'b0;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
      sram_rdata = '0; sram_ready = 1'b0;

      // Reset state
      stepCycle();
      stepCycle();
      rst = 1'b0;
      checkOutput("rst_sram_req", 32'(sram_req), 32'd0);
      checkOutput("rst_sram_addr", sram_addr, 32'd0);
      checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
      checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
      stepCycle();

      // Fetch only; ready arrives two cycles after sram_req rises
      if_req = 1'b1; if_addr = 32'h10;
      stepCycle();
      checkOutput("fo_addr", sram_addr, 32'h10);
      stepCycle();
      stepCycle();
      checkOutput("fo_stall_wait", 32'(if_stall), 32'd1);
      sram_ready = 1'b1; sram_rdata = 32'hE3A01005;
      stepCycle();
      checkOutput("fo_valid", 32'(if_valid), 32'd1);
      checkOutput("fo_data", if_rdata, 32'hE3A01005);
      checkOutput("fo_stall_pulse", 32'(if_stall), 32'd0);
      if_req = 1'b0; sram_ready = 1'b0;
      stepCycle();

      // Conflict: data wins, the fetch is granted in the mem_valid cycle
      mem_rd = 1'b1; mem_addr = 32'h40; if_req = 1'b1; if_addr = 32'h44;
      sram_ready = 1'b1; sram_rdata = 32'h1234_5678;
      stepCycle();
      checkOutput("cf_data_addr", sram_addr, 32'h40);
      stepCycle();
      checkOutput("cf_mem_valid", 32'(mem_valid), 32'd1);
      checkOutput("cf_mem_data", mem_rdata, 32'h1234_5678);
      mem_rd = 1'b0; sram_rdata = 32'hE3A01006;
      stepCycle();
      checkOutput("cf_fetch_addr", sram_addr, 32'h44);
      stepCycle();
      checkOutput("cf_if_valid", 32'(if_valid), 32'd1);
      if_req = 1'b0; sram_ready = 1'b0;
      stepCycle();

      // Store: wdata and we are held while ready is low; load data is kept
      saved = exp_mem_rdata;
      mem_wr = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hDEAD_BEEF;
      stepCycle();
      mem_addr = 32'h84; mem_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("st_we", 32'(sram_we), 32'd1);
         checkOutput("st_wdata", sram_wdata, 32'hDEAD_BEEF);
         checkOutput("st_addr", sram_addr, 32'h80);
      end
      sram_ready = 1'b1; sram_rdata = 32'h5555_AAAA;
      stepCycle();
      checkOutput("st_valid", 32'(mem_valid), 32'd1);
      checkOutput("st_rdata_kept", mem_rdata, saved);
      mem_wr = 1'b0; sram_ready = 1'b0;
      stepCycle();

      // Flush while waiting, then flush in the same cycle as ready
      if_req = 1'b1; if_addr = 32'h100;
      stepCycle();
      flush = 1'b1;
      stepCycle();
      flush = 1'b0; sram_ready = 1'b1; sram_rdata = 32'hBAD0_0001;
      stepCycle();
      checkOutput("fl_wait_valid", 32'(if_valid), 32'd0);
      if_addr = 32'h200; sram_ready = 1'b0;
      stepCycle();
      checkOutput("fl_refetch_addr", sram_addr, 32'h200);
      flush = 1'b1; sram_ready = 1'b1; sram_rdata = 32'hBAD0_0002;
      stepCycle();
      checkOutput("fl_same_valid", 32'(if_valid), 32'd0);
      flush = 1'b0; if_addr = 32'h300; sram_rdata = 32'hE1A0_0000;
      stepCycle();
      stepCycle();
      checkOutput("fl_new_valid", 32'(if_valid), 32'd1);
      checkOutput("fl_new_data", if_rdata, 32'hE1A0_0000);
      if_req = 1'b0; sram_ready = 1'b0;
      stepCycle();

      // Reset in the middle of a data access
      mem_rd = 1'b1; mem_addr = 32'h900;
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      checkOutput("rm_sram_req", 32'(sram_req), 32'd0);
      checkOutput("rm_mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("rm_mem_rdata", mem_rdata, 32'd0);
      rst = 1'b0; mem_rd = 1'b0; sram_ready = 1'b1;
      stepCycle();
      checkOutput("rm_no_valid", 32'(mem_valid), 32'd0);

      // Zero-wait SRAM with alternating fetch and load traffic
      n_if = 0; n_mem = 0;
      if_req = 1'b1; if_addr = 32'h1000; mem_rd = 1'b1; mem_addr = 32'h2000;
      for (int i = 0; i < 60; i++) begin
         sram_rdata = $urandom;
         stepCycle();
         if (if_valid) if_addr = if_addr + 32'd4;
         if (mem_valid) begin
            mem_rd = 1'b0;
            mem_addr = mem_addr + 32'd4;
         end else begin
            mem_rd = 1'b1;
         end
      end
      checkOutput("zw_progress", 32'((n_if >= 10) && (n_mem >= 10)), 32'd1);

      // Random traffic against the reference model
      for (int i = 0; i < 4000; i++) begin
         applyStimulus();
         stepCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
